// File: rtl/generador_pixeles_vga.sv
// generador_pixeles_vga: switch-selected VGA test patterns with syncs delayed to match the 2-pixel RGB pipeline.
// Mode/color are shadowed at pixel (0,0) so a frame never tears.
module generador_pixeles_vga #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int BAR_W    = 80,
   parameter int CHK_BIT  = 5,
   parameter int BORDER_W = 8
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       p_tick,
   input  logic       video_on,
   input  logic [9:0] pixel_X,
   input  logic [9:0] pixel_Y,
   input  logic       sincro_horiz_in,
   input  logic       sincro_vert_in,
   input  logic [2:0] sw_color,
   input  logic [1:0] sw_mode,
   output logic [2:0] RGB,
   output logic       sincro_horiz,
   output logic       sincro_vert,
   output logic       frame_tick
);
   logic [1:0] shadow_mode, mode1;
   logic [2:0] shadow_color, color1, bar, rgb_next;
   logic [9:0] x1, y1;
   logic       v1, hs1, vs1, latch;
   assign latch = p_tick && pixel_X == 10'd0 && pixel_Y == 10'd0;
   // bar index counts the BAR_W thresholds already passed
   always_comb begin
      bar = 3'd0;
      for (int n = 1; n < 8; n++) bar = bar + {2'b00, x1 >= 10'(BAR_W * n)};
   end
   assign rgb_next = !v1 ? 3'b000 :
                     mode1 == 2'd0 ? color1 :
                     mode1 == 2'd1 ? bar :
                     mode1 == 2'd2 ? ((x1[CHK_BIT] ^ y1[CHK_BIT]) ? color1 : ~color1) :
                     (x1 < 10'(BORDER_W) || x1 >= 10'(H_ACTIVE - BORDER_W) ||
                      y1 < 10'(BORDER_W) || y1 >= 10'(V_ACTIVE - BORDER_W)) ? 3'b111 : color1;
   always_ff @(posedge CLK)
      if (RESET) begin
         shadow_mode  <= 2'd0;
         shadow_color <= 3'd0;
         frame_tick   <= 1'b0;
         x1           <= 10'd0;
         y1           <= 10'd0;
         v1           <= 1'b0;
         hs1          <= 1'b1;
         vs1          <= 1'b1;
         mode1        <= 2'd0;
         color1       <= 3'd0;
         RGB          <= 3'd0;
         sincro_horiz <= 1'b1;
         sincro_vert  <= 1'b1;
      end else begin
         frame_tick <= latch;
         if (latch) begin
            shadow_mode  <= sw_mode;
            shadow_color <= sw_color;
         end
         // pixel (0,0) must already see the values latched on this edge
         if (p_tick) begin
            x1           <= pixel_X;
            y1           <= pixel_Y;
            v1           <= video_on;
            hs1          <= sincro_horiz_in;
            vs1          <= sincro_vert_in;
            mode1        <= latch ? sw_mode : shadow_mode;
            color1       <= latch ? sw_color : shadow_color;
            RGB          <= rgb_next;
            sincro_horiz <= hs1;
            sincro_vert  <= vs1;
         end
      end
endmodule

// File: tb/tb_generador_pixeles_vga.sv
// tb_generador_pixeles_vga: directed and randomized checks of the pattern generator against a
// pixel-level model of the visible result (pattern of each pixel emerging two pixel ticks later).
module tb_generador_pixeles_vga;
   logic       CLK = 1'b0, RESET = 1'b1, p_tick = 1'b0, video_on = 1'b0;
   logic [9:0] pixel_X = 10'd0, pixel_Y = 10'd0;
   logic       sincro_horiz_in = 1'b1, sincro_vert_in = 1'b1;
   logic [2:0] sw_color = 3'd0;
   logic [1:0] sw_mode = 2'd0;
   logic [2:0] RGB;
   logic       sincro_horiz, sincro_vert, frame_tick;
   int         tests = 0, fails = 0;
   generador_pixeles_vga dut (
      .CLK(CLK), .RESET(RESET), .p_tick(p_tick), .video_on(video_on),
      .pixel_X(pixel_X), .pixel_Y(pixel_Y),
      .sincro_horiz_in(sincro_horiz_in), .sincro_vert_in(sincro_vert_in),
      .sw_color(sw_color), .sw_mode(sw_mode),
      .RGB(RGB), .sincro_horiz(sincro_horiz), .sincro_vert(sincro_vert), .frame_tick(frame_tick)
   );
   always #5 CLK = ~CLK;
   function automatic logic [2:0] pat(input logic [1:0] m, input logic [2:0] c, input int x, input int y, input bit v);
      if (!v) return 3'b000;
      case (m)
         2'd0:    return c;
         2'd1:    return 3'(x / 80);
         2'd2:    return (((x / 32) + (y / 32)) % 2 == 1) ? c : ~c;
         default: return (x < 8 || x >= 632 || y < 8 || y >= 472) ? 3'b111 : c;
      endcase
   endfunction
   // model: what the screen must show, one pixel result per tick, delayed by two ticks
   logic [1:0] sh_m;
   logic [2:0] sh_c, s1_rgb, e_rgb;
   logic       s1_hs, s1_vs, e_hs, e_vs, e_ft, started = 1'b0;
   logic       lat;
   assign lat = p_tick && pixel_X == 10'd0 && pixel_Y == 10'd0;
   always @(posedge CLK)
      if (RESET) begin
         started <= 1'b1;
         sh_m <= 2'd0; sh_c <= 3'd0;
         s1_rgb <= 3'd0; s1_hs <= 1'b1; s1_vs <= 1'b1;
         e_rgb <= 3'd0; e_hs <= 1'b1; e_vs <= 1'b1; e_ft <= 1'b0;
      end else begin
         e_ft <= lat;
         if (lat) begin
            sh_m <= sw_mode;
            sh_c <= sw_color;
         end
         if (p_tick) begin
            e_rgb <= s1_rgb; e_hs <= s1_hs; e_vs <= s1_vs;
            s1_rgb <= pat(lat ? sw_mode : sh_m, lat ? sw_color : sh_c, int'(pixel_X), int'(pixel_Y), video_on);
            s1_hs <= sincro_horiz_in; s1_vs <= sincro_vert_in;
         end
      end
   task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask
   always @(negedge CLK)
      if (started) chk("cycle", {RGB, sincro_horiz, sincro_vert, frame_tick}, {e_rgb, e_hs, e_vs, e_ft});
   // one pixel period: p_tick high for one CLK, then low (plus optional idle CLKs)
   task automatic pix(input int x, input int y, input int gap = 0);
      @(negedge CLK);
      p_tick = 1'b1;
      pixel_X = 10'(x);
      pixel_Y = 10'(y);
      video_on = x < 640 && y < 480;
      sincro_horiz_in = !(x >= 656 && x < 752);
      sincro_vert_in = !(y == 490 || y == 491);
      @(negedge CLK);
      p_tick = 1'b0;
      repeat (gap) @(negedge CLK);
   endtask
   task automatic frame_start();
      pix(799, 524);
      pix(0, 0);
   endtask
   int pts[8] = '{79, 80, 240, 319, 560, 639, 640, 799};
   logic [2:0] bar_exp[8] = '{3'd0, 3'd1, 3'd3, 3'd3, 3'd7, 3'd7, 3'd0, 3'd0};
   initial begin
      repeat (3) pix(400, 300);
      chk("reset_hold", {RGB, sincro_horiz, sincro_vert, frame_tick}, 6'b000110);
      RESET = 1'b0;
      pix(401, 300);
      pix(402, 300);
      chk("post_reset", {RGB, sincro_horiz, sincro_vert, frame_tick}, 6'b000110);
      sw_mode = 2'd0; sw_color = 3'b101;
      frame_start();
      chk("latch_tick", {2'b00, RGB, frame_tick}, {2'b00, 3'b000, 1'b1});
      pix(1, 0);
      chk("latency_rgb", {3'b000, RGB}, {3'b000, 3'b101});
      pix(655, 0);
      pix(656, 0);
      chk("hs_before", {5'b0, sincro_horiz}, 6'd1);
      pix(657, 0);
      chk("hs_after", {5'b0, sincro_horiz}, 6'd0);
      sw_color = 3'b010;
      pix(100, 200);
      pix(101, 200);
      chk("hold_y200", {3'b000, RGB}, {3'b000, 3'b101});
      pix(100, 479);
      pix(101, 479);
      chk("hold_y479", {3'b000, RGB}, {3'b000, 3'b101});
      frame_start();
      chk("new_frame_tick", {5'b0, frame_tick}, 6'd1);
      pix(1, 0);
      chk("new_color", {3'b000, RGB}, {3'b000, 3'b010});
      sw_mode = 2'd1;
      frame_start();
      for (int x = 0; x <= 800; x++) begin
         pix(x == 800 ? 0 : x, x == 800 ? 101 : 100);
         for (int k = 0; k < 8; k++)
            if (x - 1 == pts[k]) chk($sformatf("bar_x%0d", pts[k]), {3'b000, RGB}, {3'b000, bar_exp[k]});
      end
      sw_mode = 2'd2; sw_color = 3'b100;
      frame_start();
      pix(32, 0);
      chk("chk_0_0", {3'b000, RGB}, {3'b000, 3'b011});
      pix(32, 32);
      chk("chk_32_0", {3'b000, RGB}, {3'b000, 3'b100});
      pix(5, 5);
      chk("chk_32_32", {3'b000, RGB}, {3'b000, 3'b011});
      sw_mode = 2'd3;
      frame_start();
      pix(7, 100);
      pix(8, 100);
      chk("border_7", {3'b000, RGB}, {3'b000, 3'b111});
      pix(320, 472);
      chk("border_8", {3'b000, RGB}, {3'b000, 3'b100});
      pix(320, 100);
      chk("border_472", {3'b000, RGB}, {3'b000, 3'b111});
      pix(300, 240);
      @(negedge CLK) RESET = 1'b1;
      @(negedge CLK);
      chk("mid_reset", {3'b000, RGB, sincro_horiz, sincro_vert}, 6'b000011);
      RESET = 1'b0;
      pix(300, 240);
      pix(301, 240);
      chk("after_reset_shadow", {3'b000, RGB}, 6'd0);
      repeat (20) begin
         @(negedge CLK);
         pixel_X = 10'($urandom_range(0, 799));
         pixel_Y = 10'($urandom_range(0, 524));
         video_on = 1'($urandom);
         sincro_horiz_in = 1'($urandom);
         sincro_vert_in = 1'($urandom);
         sw_color = 3'($urandom);
         sw_mode = 2'($urandom);
      end
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            @(negedge CLK) RESET = 1'b1;
            @(negedge CLK) RESET = 1'b0;
         end
         if ($urandom_range(0, 9) == 0) begin
            sw_color = 3'($urandom);
            sw_mode = 2'($urandom);
         end
         if ($urandom_range(0, 15) == 0) pix(0, 0, $urandom_range(0, 2));
         else pix($urandom_range(0, 799), $urandom_range(0, 524), $urandom_range(0, 2));
      end
      @(negedge CLK);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/generador_pixeles_vga.md
Name: generador_pixeles_vga

Overview:
- Pixel generator directly downstream of Sincronizador_VGA.
- Consumes its p_tick, pixel_X, pixel_Y, video_on, sincro_horiz and sincro_vert outputs and produces 3-bit RGB from a switch-selected test pattern.
- Delays both sync signals through its own pipeline so the RGB and sync outputs reach the connector aligned.
- Mode and color are captured once per frame, so switch changes never tear a frame.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- BAR_W, 80, width in pixels of each vertical color bar (H_ACTIVE/8).
- CHK_BIT, 5, pixel_X/pixel_Y bit used for checkerboard squares (32 px).
- BORDER_W, 8, border thickness in pixels.

Ports:
- CLK  in  1  system clock (50 MHz).
- RESET  in  1  synchronous, active-high reset.
- p_tick  in  1  pixel-rate enable from the sync generator (one CLK-wide pulse every 2 CLK).
- video_on  in  1  high while pixel_X < H_ACTIVE and pixel_Y < V_ACTIVE.
- pixel_X  in  10  current column.
- pixel_Y  in  10  current row.
- sincro_horiz_in  in  1  hsync from the sync generator, active low.
- sincro_vert_in  in  1  vsync from the sync generator, active low.
- sw_color  in  3  user color {R,G,B}.
- sw_mode  in  2  pattern select.
- RGB  out  3  registered pixel color {R,G,B}.
- sincro_horiz  out  1  hsync delayed to match RGB.
- sincro_vert  out  1  vsync delayed to match RGB.
- frame_tick  out  1  one-CLK pulse when the mode/color shadow registers load.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-high, named RESET.
  - All pipeline registers advance only on CLK edges where p_tick=1; when p_tick=0 they hold.
- Reset values:
  - RGB=0, sincro_horiz=1, sincro_vert=1, frame_tick=0.
  - Shadow mode=0, shadow color=0.
  - All pipeline valid/video flags=0; delayed syncs=1.
- Frame latch:
  - On an edge where p_tick=1, pixel_X=0 and pixel_Y=0: shadow_mode<=sw_mode, shadow_color<=sw_color, and frame_tick=1 for that single CLK.
  - Shadow values are stable for the whole frame.
  - The pixel (0,0) itself uses the newly latched values.
  - Latch and pipeline advance happen on the same edge, with no conflict.
- Stage 1 (p_tick edge):
  - Register pixel_X, pixel_Y, video_on, sincro_horiz_in and sincro_vert_in.
  - Register the shadow values: the next-value form at (0,0), otherwise the current value.
- Stage 2 (next p_tick edge): compute the pattern from the stage-1 registers into RGB; syncs are copied from stage 1.
- Latency: input sampled at p_tick edge k appears on the outputs after p_tick edge k+1. That is 2 pixel periods (4 CLK), identical for RGB and syncs.
- Patterns (stage-1 video flag=0 forces RGB=3'b000 in every mode):
  - mode 0 solid: RGB=shadow_color.
  - mode 1 bars: bar index i = number of thresholds BAR_W*n (n=1..7) that are <= X; RGB=i[2:0].
    - Implement with comparators, not division.
    - X=79 gives 0, X=80 gives 1, X=639 gives 7.
  - mode 2 checker: RGB = (X[CHK_BIT]^Y[CHK_BIT]) ? shadow_color : ~shadow_color.
  - mode 3 border: RGB=3'b111 if X<BORDER_W or X>=H_ACTIVE-BORDER_W or Y<BORDER_W or Y>=V_ACTIVE-BORDER_W; otherwise shadow_color.
- Widths: all comparisons use unsigned 10-bit arithmetic; the constants fit in 10 bits.
- Boundary conditions:
  - Switch change mid-frame: no visible effect until the next (0,0).
  - Reset asserted mid-frame: outputs return to reset values on the next CLK edge, independent of p_tick.
  - After reset deasserts, RGB stays 0 until the first valid visible pixel propagates.
  - p_tick stuck low: outputs freeze with no corruption.

Test Plan:
- Reset: hold RESET 5 CLK, then release with p_tick toggling -> RGB=0, both syncs=1, frame_tick=0 until the first (0,0) is reached.
- Latency/alignment: mode 0, sw_color=3'b101, drive video_on 0->1 at X=0 -> RGB goes 0->101 exactly 2 p_ticks later. A sincro_horiz_in falling edge appears on sincro_horiz after the same 2 p_ticks.
- Frame latch: set sw_color=3'b010 mid-frame (Y=200) -> RGB stays at the old color through Y=479. At the next (0,0), frame_tick pulses 1 CLK and RGB becomes 010.
- Bars: mode 1, scan line Y=100 -> RGB=0 at X=0..79, 1 at X=80, 3 at X=240..319, 7 at X=560..639; 0 during blanking (X=640..799).
- Checker/border: mode 2, color=3'b100 -> (0,0)=011, (32,0)=100, (32,32)=011. Mode 3 -> (7,100)=111, (8,100)=color, (320,472)=111.
- Mid-frame reset: assert RESET at X=300, Y=240 -> next CLK RGB=0 and syncs=1. After release, the shadow holds mode 0/color 0 (RGB=0 on visible pixels) until the next (0,0) latch.
